// File: rtl/lenet_layer_ctrl.sv
// Layer sequencer for the LeNet convolution datapath: weight preload, feature-map
// streaming and write-back flush for one command, ending in a one-cycle done pulse.
module lenet_layer_ctrl #(
    parameter int ADDR_WIDTH   = 11,
    parameter int N            = 5,
    parameter int WLOC_W       = $clog2(N*N),
    parameter int FLUSH_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [2:0]            cmd_mode,
    input  logic [ADDR_WIDTH-1:0] weight_base,
    input  logic [ADDR_WIDTH-1:0] ifmap_base,
    input  logic [ADDR_WIDTH-1:0] ifmap_len,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  ctrl_ram_en,
    output logic                  ctrl_addr_ctrl_en,
    output logic                  ctrl_WorI,
    output logic [2:0]            ctrl_mode,
    output logic [ADDR_WIDTH-1:0] ctrl_read_addr,
    output logic [WLOC_W-1:0]     ctrl_weight_location,
    output logic [1:0]            ctrl_mux_sel
);

    localparam int unsigned NW   = N * N;
    localparam int          FC_W = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_wbase;
    logic [ADDR_WIDTH-1:0] r_ibase;
    logic [ADDR_WIDTH-1:0] r_len;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [FC_W-1:0]       r_fcnt;

    // Outputs are updated on the transition into each state, so r_cnt always
    // holds the index of the next address to emit.
    always_ff @(posedge clk) begin
        if (rst || (abort && r_state != S_IDLE) || r_state == S_DONE) begin
            r_state              <= S_IDLE;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            ctrl_ram_en          <= 1'b0;
            ctrl_addr_ctrl_en    <= 1'b0;
            ctrl_WorI            <= 1'b0;
            ctrl_mode            <= '0;
            ctrl_read_addr       <= '0;
            ctrl_weight_location <= '0;
            ctrl_mux_sel         <= '0;
            r_cnt                <= '0;
            r_fcnt               <= '0;
            if (rst) begin
                r_wbase <= '0;
                r_ibase <= '0;
                r_len   <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_wbase      <= weight_base;
                        r_ibase      <= ifmap_base;
                        r_len        <= ifmap_len;
                        busy         <= 1'b1;
                        ctrl_mode    <= cmd_mode;
                        ctrl_mux_sel <= (op == 2'd3) ? 2'd2 : op;
                        if (op == 2'd0) begin
                            r_state              <= S_LOAD_W;
                            ctrl_ram_en          <= 1'b1;
                            ctrl_WorI            <= 1'b1;
                            ctrl_read_addr       <= weight_base;
                            ctrl_weight_location <= '0;
                            r_cnt                <= ADDR_WIDTH'(1);
                        end else if (ifmap_len != '0) begin
                            r_state           <= S_STREAM;
                            ctrl_ram_en       <= 1'b1;
                            ctrl_addr_ctrl_en <= 1'b1;
                            ctrl_read_addr    <= ifmap_base;
                            r_cnt             <= ADDR_WIDTH'(1);
                        end else begin
                            r_state           <= S_FLUSH;
                            ctrl_addr_ctrl_en <= 1'b1;
                            r_fcnt            <= FC_W'(1);
                        end
                    end
                end
                S_LOAD_W: begin
                    if (r_cnt == ADDR_WIDTH'(NW)) begin
                        ctrl_WorI         <= 1'b0;
                        ctrl_addr_ctrl_en <= 1'b1;
                        if (r_len != '0) begin
                            r_state        <= S_STREAM;
                            ctrl_read_addr <= r_ibase;
                            r_cnt          <= ADDR_WIDTH'(1);
                        end else begin
                            r_state     <= S_FLUSH;
                            ctrl_ram_en <= 1'b0;
                            r_fcnt      <= FC_W'(1);
                        end
                    end else begin
                        ctrl_read_addr       <= r_wbase + r_cnt;
                        ctrl_weight_location <= WLOC_W'(r_cnt);
                        r_cnt                <= r_cnt + ADDR_WIDTH'(1);
                    end
                end
                S_STREAM: begin
                    if (r_cnt == r_len) begin
                        r_state     <= S_FLUSH;
                        ctrl_ram_en <= 1'b0;
                        r_fcnt      <= FC_W'(1);
                    end else begin
                        ctrl_read_addr <= r_ibase + r_cnt;
                        r_cnt          <= r_cnt + ADDR_WIDTH'(1);
                    end
                end
                S_FLUSH: begin
                    if (r_fcnt == FC_W'(FLUSH_CYCLES)) begin
                        r_state           <= S_DONE;
                        ctrl_addr_ctrl_en <= 1'b0;
                        done              <= 1'b1;
                    end else begin
                        r_fcnt <= r_fcnt + FC_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
